// File: rtl/bram_dump_streamer_pkg.sv
// Shared types and constants for the BRAM dump streamer.
// Widths mirror the data BRAM debug port.
package bram_dump_streamer_pkg;

  localparam int D_BRAM_ADDR_WIDTH = 12;
  localparam int DUMP_DATA_WIDTH   = 32;
  localparam int DUMP_COUNT_WIDTH  = 11;
  localparam int BYTES_PER_WORD    = 4;

  typedef enum logic [2:0] {
    DUMP_IDLE = 3'd0,
    DUMP_ADDR = 3'd1,
    DUMP_WAIT = 3'd2,
    DUMP_SEND = 3'd3,
    DUMP_DONE = 3'd4
  } dump_state_e;

endpackage

// File: rtl/bram_dump_streamer_if.sv
// Byte stream handshake from the dump streamer to its consumer.
// The master drives data/valid, the slave returns ready.
interface bram_dump_streamer_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/bram_dump_streamer_ser.sv
// Word serializer: loads one word, emits its bytes LSB first.
// clear wins over load so an abort always leaves the stream idle.
module bram_dump_streamer_ser
  import bram_dump_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = DUMP_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  ready,
  output logic [7:0]            data,
  output logic                  valid,
  output logic                  last
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  vld_q, vld_d;

  assign data  = sreg_q[7:0];
  assign valid = vld_q;
  assign last  = (idx_q == IW'(NB - 1));

  always_comb begin
    sreg_d = sreg_q;
    idx_d  = idx_q;
    vld_d  = vld_q;
    if (clear) begin
      vld_d = 1'b0;
    end else if (load) begin
      sreg_d = word;
      idx_d  = '0;
      vld_d  = 1'b1;
    end else if (vld_q && ready) begin
      sreg_d = sreg_q >> 8;
      idx_d  = idx_q + IW'(1);
      if (last) vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      idx_q  <= idx_d;
      vld_q  <= vld_d;
    end
  end

endmodule

// File: rtl/bram_dump_streamer.sv
// Walks a range of data BRAM via its debug port and streams it
// out as bytes; owns debug_addr while busy.
module bram_dump_streamer
  import bram_dump_streamer_pkg::*;
#(
  parameter int ADDR_WIDTH  = D_BRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DUMP_DATA_WIDTH,
  parameter int COUNT_WIDTH = DUMP_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_WIDTH-1:0]  start_addr,
  input  logic [COUNT_WIDTH-1:0] word_count,
  output logic [ADDR_WIDTH-1:0]  debug_addr,
  input  logic [DATA_WIDTH-1:0]  debug_data,
  bram_dump_streamer_if.master   tx,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] words_sent
);

  dump_state_e            state_q, state_d;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d;
  logic [COUNT_WIDTH-1:0] sent_q, sent_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;

  logic       ser_load;
  logic       ser_clear;
  logic       ser_valid;
  logic       ser_last;
  logic [7:0] ser_data;
  logic       accept;
  logic       unused_addr_lsb;

  assign unused_addr_lsb = ^start_addr[1:0];

  assign accept      = ser_valid && tx.tx_ready;
  assign tx.tx_valid = ser_valid;
  assign tx.tx_data  = ser_data;
  assign debug_addr  = addr_q;
  assign words_sent  = sent_q;
  assign busy        = (state_q != DUMP_IDLE);
  assign done        = (state_q == DUMP_DONE);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    sent_d    = sent_q;
    addr_d    = addr_q;
    ser_load  = 1'b0;
    ser_clear = 1'b0;
    unique case (state_q)
      DUMP_IDLE: begin
        if (start && !abort) begin
          rem_d   = word_count;
          addr_d  = {start_addr[ADDR_WIDTH-1:2], 2'b00};
          sent_d  = '0;
          state_d = (word_count == '0) ? DUMP_DONE : DUMP_ADDR;
        end
      end
      DUMP_ADDR: state_d = DUMP_WAIT;
      DUMP_WAIT: begin
        ser_load = 1'b1;
        state_d  = DUMP_SEND;
      end
      DUMP_SEND: begin
        if (accept && ser_last) begin
          sent_d  = sent_q + COUNT_WIDTH'(1);
          rem_d   = rem_q - COUNT_WIDTH'(1);
          addr_d  = addr_q + ADDR_WIDTH'(4);
          state_d = (rem_q == COUNT_WIDTH'(1)) ? DUMP_DONE
                                               : DUMP_ADDR;
        end
      end
      DUMP_DONE: state_d = DUMP_IDLE;
      default:   state_d = DUMP_IDLE;
    endcase
    // A byte taken on the abort edge still counts above.
    if (abort && state_q != DUMP_IDLE) begin
      state_d   = DUMP_IDLE;
      ser_clear = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DUMP_IDLE;
      rem_q   <= '0;
      sent_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sent_q  <= sent_d;
      addr_q  <= addr_d;
    end
  end

  bram_dump_streamer_ser #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk   (clk),
    .rst   (rst),
    .load  (ser_load),
    .clear (ser_clear),
    .word  (debug_data),
    .ready (tx.tx_ready),
    .data  (ser_data),
    .valid (ser_valid),
    .last  (ser_last)
  );

endmodule
